axi_rd_slave: RTL and testbench
===============================

// Module: axi_rd_slave
// PURPOSE
//  AXI4 read responder. It terminates the AR channel driven by the pad-side AR delay FIFO and
//  returns R beats from a single-port synchronous SRAM model.
//  - Holds a 2-entry AR queue.
//  - A burst engine generates FIXED/INCR/WRAP beat addresses.
//  - A 2-entry R output buffer absorbs rready backpressure without losing SRAM data.
// PARAMETERS
//  DATA_W      128           R data width in bits; SRAM word width
//  MEM_AW      13            SRAM word-address bits (8192 x 128b = 128 KB)
//  SRAM_START  40'h00000000  lowest decoded byte address
//  SRAM_END    40'h0001ffff  highest decoded byte address; addresses outside -> DECERR
// PORTS
//  cpu_clk          in   1        clock
//  cpu_rst_b        in   1        reset, asynchronous, active-low
//  pad_araddr       in   40       AR byte address
//  pad_arburst      in   2        00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  pad_arid         in   8        AR transaction id
//  pad_arlen        in   8        beats-1
//  pad_arsize       in   3        bytes/beat = 1<<arsize
//  pad_arvalid      in   1        AR valid
//  pad_arready      out  1        AR ready
//  pad_rid          out  8        R id, equal to arid of the owning burst
//  pad_rdata        out  DATA_W   R data
//  pad_rresp        out  2        00 OKAY, 10 SLVERR, 11 DECERR
//  pad_rlast        out  1        last beat of burst
//  pad_rvalid       out  1        R valid
//  pad_rready       in   1        R ready
//  mem_cen          out  1        SRAM read enable, active high
//  mem_addr         out  MEM_AW   SRAM word address = beat_addr[MEM_AW+3:4]
//  mem_rdata        in   DATA_W   SRAM data, valid the cycle after mem_cen
// BEHAVIOUR
//  Reset values (all outputs): pad_arready=0 while cpu_rst_b low, then 1; pad_rvalid=0,
//   pad_rlast=0, pad_rid=0, pad_rresp=0, pad_rdata=0, mem_cen=0, mem_addr=0.
//  AR queue:
//   - pad_arready = !queue_full.
//   - An entry is pushed on arvalid&&arready.
//   - Push to a full queue cannot occur.
//   - Simultaneous push and pop keep the count.
//  Error classification, decided at the AR handshake and stored per entry:
//   - addr outside [SRAM_START,SRAM_END] -> DECERR.
//   - else arsize>4, arburst==11, or WRAP with arlen not in {1,3,7,15} -> SLVERR.
//   - else OKAY.
//  Burst engine FSM, states IDLE and BURST:
//   - IDLE & queue non-empty & credit -> issue beat 0 from the queue head in that cycle; pop.
//     Go to BURST if arlen>0, else stay IDLE.
//   - BURST: issue one beat per cycle while credit is available.
//     After issuing beat arlen -> IDLE, or directly load the next queue head.
//   - Credit = (R buffer count + beats in flight) < 2, counting the beat leaving the buffer
//     this cycle.
//  Beat address generation:
//   - FIXED: every beat uses the start address.
//   - INCR: beat n+1 = align(addr,size) + (1<<size). Beat 0 keeps the unaligned address.
//   - WRAP: boundary = (len+1)<<size. Next = (addr & ~(boundary-1)) | ((addr+(1<<size)) & (boundary-1)).
//   - No 4 KB boundary check. Arithmetic is 40-bit and wraps modulo 2^40.
//  Memory access:
//   - mem_cen=1 only for OKAY beats.
//   - Error beats bypass the SRAM, travel through the same 1-cycle stage, and return rdata=0.
//     This keeps ordering.
//  R buffer:
//   - 2-entry FIFO carrying {rid, rdata, rresp, rlast}.
//   - It is written one cycle after issue with mem_rdata (OKAY) or 0 (error).
//   - Pop on rvalid&&rready.
//   - R outputs are driven from the head register.
//  Latency:
//   - AR handshake in cycle 0 -> mem_cen in cycle 1 -> rvalid in cycle 3.
//   - Throughput is 1 beat/cycle when rready is held 1.
//   - Bursts are returned in AR order with no interleaving.
//   - R outputs are stable while rvalid&&!rready.
//  rlast is set on beat index arlen. A single-beat burst has rlast=1 on its only beat.
//  Reset mid-burst: queue, FSM, in-flight beats and R buffer all clear. Remaining beats are dropped.
// TESTING
//  1. INCR, addr 0x100, len 3, size 4, rready=1
//     -> mem_addr 0x10..0x13 in consecutive cycles.
//     -> rvalid 4 consecutive beats from cycle 3; rlast on beat 3; rresp 00.
//  2. WRAP, addr 0x130, len 3, size 4
//     -> mem_addr sequence 0x13, 0x10, 0x11, 0x12.
//  3. addr 0x20000, len 1
//     -> 2 beats, rresp 11, rdata 0, mem_cen never asserted.
//  4. Three back-to-back ARs, ids 1, 2, 3, with rready held 0
//     -> arready drops after the queue fills.
//     -> no more than 2 beats are buffered and no data is lost.
//     -> after rready=1, R ids return in order 1, 2, 3.
//  5. INCR, len 7, rready toggled 1/0 each cycle
//     -> 8 beats with correct data.
//     -> rdata/rid/rlast stable during every stall.
//  6. Assert cpu_rst_b low during beat 2 of a len 7 burst
//     -> rvalid=0 immediately.
//     -> after release, arready=1 and a new len 0 burst returns 1 beat with rlast=1.

Source files
------------

// File: rtl/axi_rd_slave.sv
// AXI4 read responder: 2-entry AR queue, FIXED/INCR/WRAP burst engine, one-cycle SRAM stage
// and a 2-entry R buffer that absorbs rready backpressure without dropping SRAM data.
module axi_rd_slave #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned MEM_AW     = 13,
    parameter logic [39:0] SRAM_START = 40'h00_0000_0000,
    parameter logic [39:0] SRAM_END   = 40'h00_0001_ffff
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_b,
    input  logic [39:0]       pad_araddr,
    input  logic [1:0]        pad_arburst,
    input  logic [7:0]        pad_arid,
    input  logic [7:0]        pad_arlen,
    input  logic [2:0]        pad_arsize,
    input  logic              pad_arvalid,
    output logic              pad_arready,
    output logic [7:0]        pad_rid,
    output logic [DATA_W-1:0] pad_rdata,
    output logic [1:0]        pad_rresp,
    output logic              pad_rlast,
    output logic              pad_rvalid,
    input  logic              pad_rready,
    output logic              mem_cen,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef struct packed {
        logic [39:0] addr;
        logic [1:0]  burst;
        logic [7:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  resp;
    } ar_t;

    typedef struct packed {
        logic [7:0]        id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_t;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    function automatic logic [39:0] next_addr(input logic [39:0] addr, input logic [1:0] burst,
                                              input logic [7:0] len, input logic [2:0] size);
        logic [39:0] bytes;
        logic [39:0] bound;
        bytes = 40'd1 << size;
        bound = ({32'd0, len} + 40'd1) << size;
        unique case (burst)
            BurstFixed: next_addr = addr;
            BurstWrap:  next_addr = (addr & ~(bound - 40'd1)) | ((addr + bytes) & (bound - 40'd1));
            default:    next_addr = (addr & ~(bytes - 40'd1)) + bytes;
        endcase
    endfunction

    // ---------------------------------------------------------------- AR queue
    ar_t        arq0_q, arq0_d, arq1_q, arq1_d, ar_in;
    logic [1:0] arq_cnt_q, arq_cnt_d;
    logic       arq_push, arq_pop;
    logic       ar_dec_err, ar_slv_err, wrap_len_ok;

    // Offset compare keeps the range check free of a constant lower bound.
    assign ar_dec_err  = (pad_araddr - SRAM_START) > (SRAM_END - SRAM_START);
    assign wrap_len_ok = (pad_arlen == 8'd1) || (pad_arlen == 8'd3) ||
                         (pad_arlen == 8'd7) || (pad_arlen == 8'd15);
    assign ar_slv_err  = (pad_arsize > 3'd4) || (pad_arburst == 2'b11) ||
                         ((pad_arburst == BurstWrap) && !wrap_len_ok);

    always_comb begin
        ar_in.addr  = pad_araddr;
        ar_in.burst = pad_arburst;
        ar_in.id    = pad_arid;
        ar_in.len   = pad_arlen;
        ar_in.size  = pad_arsize;
        if (ar_dec_err) begin
            ar_in.resp = RespDecErr;
        end else if (ar_slv_err) begin
            ar_in.resp = RespSlvErr;
        end else begin
            ar_in.resp = RespOkay;
        end
    end

    assign pad_arready = cpu_rst_b && (arq_cnt_q != 2'd2);
    assign arq_push    = pad_arvalid && pad_arready;

    always_comb begin
        arq0_d    = arq0_q;
        arq1_d    = arq1_q;
        arq_cnt_d = arq_cnt_q;
        if (arq_pop) begin
            arq0_d = arq1_q;
        end
        if (arq_push) begin
            if ((arq_cnt_q == 2'd2) || ((arq_cnt_q == 2'd1) && !arq_pop)) begin
                arq1_d = ar_in;
            end else begin
                arq0_d = ar_in;
            end
        end
        if (arq_push && !arq_pop) begin
            arq_cnt_d = arq_cnt_q + 2'd1;
        end else if (!arq_push && arq_pop) begin
            arq_cnt_d = arq_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            arq0_q    <= '0;
            arq1_q    <= '0;
            arq_cnt_q <= 2'd0;
        end else begin
            arq0_q    <= arq0_d;
            arq1_q    <= arq1_d;
            arq_cnt_q <= arq_cnt_d;
        end
    end

    // ---------------------------------------------------------------- burst engine
    state_e     state_q, state_d;
    ar_t        bst_q, bst_d;
    logic [7:0] beat_q, beat_d;
    logic       credit;
    logic       iss_valid, iss_last;
    logic [7:0] iss_id;
    logic [1:0] iss_resp;
    logic [1:0] rb_cnt_q, rb_cnt_d;
    logic       s1_valid_q;
    logic       rb_pop;
    logic [2:0] occupancy;

    // A beat leaving the R buffer this cycle frees its slot for the beat issued now.
    assign occupancy = {1'b0, rb_cnt_q} + {2'b0, s1_valid_q} - {2'b0, rb_pop};
    assign credit    = occupancy < 3'd2;

    always_comb begin
        state_d   = state_q;
        bst_d     = bst_q;
        beat_d    = beat_q;
        arq_pop   = 1'b0;
        iss_valid = 1'b0;
        iss_last  = 1'b0;
        iss_id    = 8'd0;
        iss_resp  = RespOkay;
        mem_cen   = 1'b0;
        mem_addr  = '0;
        unique case (state_q)
            StIdle: begin
                if ((arq_cnt_q != 2'd0) && credit) begin
                    arq_pop   = 1'b1;
                    iss_valid = 1'b1;
                    iss_id    = arq0_q.id;
                    iss_resp  = arq0_q.resp;
                    iss_last  = (arq0_q.len == 8'd0);
                    if (arq0_q.resp == RespOkay) begin
                        mem_cen  = 1'b1;
                        mem_addr = arq0_q.addr[MEM_AW+3:4];
                    end
                    if (arq0_q.len != 8'd0) begin
                        bst_d      = arq0_q;
                        bst_d.addr = next_addr(arq0_q.addr, arq0_q.burst, arq0_q.len,
                                               arq0_q.size);
                        beat_d     = 8'd1;
                        state_d    = StBurst;
                    end
                end
            end
            StBurst: begin
                if (credit) begin
                    iss_valid  = 1'b1;
                    iss_id     = bst_q.id;
                    iss_resp   = bst_q.resp;
                    iss_last   = (beat_q == bst_q.len);
                    if (bst_q.resp == RespOkay) begin
                        mem_cen  = 1'b1;
                        mem_addr = bst_q.addr[MEM_AW+3:4];
                    end
                    bst_d.addr = next_addr(bst_q.addr, bst_q.burst, bst_q.len, bst_q.size);
                    beat_d     = beat_q + 8'd1;
                    if (beat_q == bst_q.len) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            state_q <= StIdle;
            bst_q   <= '0;
            beat_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            bst_q   <= bst_d;
            beat_q  <= beat_d;
        end
    end

    // ---------------------------------------------------------------- SRAM stage
    logic [7:0] s1_id_q;
    logic [1:0] s1_resp_q;
    logic       s1_last_q;

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= 8'd0;
            s1_resp_q  <= RespOkay;
            s1_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= iss_valid;
            s1_id_q    <= iss_id;
            s1_resp_q  <= iss_resp;
            s1_last_q  <= iss_last;
        end
    end

    // ---------------------------------------------------------------- R buffer
    r_t   rb0_q, rb0_d, rb1_q, rb1_d, rb_in;
    logic rb_push;

    assign rb_push    = s1_valid_q;
    assign rb_pop     = pad_rvalid && pad_rready;
    assign rb_in.id   = s1_id_q;
    assign rb_in.data = (s1_resp_q == RespOkay) ? mem_rdata : '0;
    assign rb_in.resp = s1_resp_q;
    assign rb_in.last = s1_last_q;

    always_comb begin
        rb0_d    = rb0_q;
        rb1_d    = rb1_q;
        rb_cnt_d = rb_cnt_q;
        if (rb_pop) begin
            rb0_d = rb1_q;
        end
        if (rb_push) begin
            if ((rb_cnt_q == 2'd2) || ((rb_cnt_q == 2'd1) && !rb_pop)) begin
                rb1_d = rb_in;
            end else begin
                rb0_d = rb_in;
            end
        end
        if (rb_push && !rb_pop) begin
            rb_cnt_d = rb_cnt_q + 2'd1;
        end else if (!rb_push && rb_pop) begin
            rb_cnt_d = rb_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            rb0_q    <= '0;
            rb1_q    <= '0;
            rb_cnt_q <= 2'd0;
        end else begin
            rb0_q    <= rb0_d;
            rb1_q    <= rb1_d;
            rb_cnt_q <= rb_cnt_d;
        end
    end

    assign pad_rvalid = (rb_cnt_q != 2'd0);
    assign pad_rid    = rb0_q.id;
    assign pad_rdata  = rb0_q.data;
    assign pad_rresp  = rb0_q.resp;
    assign pad_rlast  = rb0_q.last;

endmodule

// File: tb/tb_axi_rd_slave.sv
// Bench for axi_rd_slave: directed read scenarios plus randomized bursts, checked by a
// scoreboard fed from a transaction-level reference model of the expected R beats.
`timescale 1ns/1ps
module tb_axi_rd_slave;
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned MEM_AW     = 13;
    localparam logic [39:0] SRAM_START = 40'h00_0000_0000;
    localparam logic [39:0] SRAM_END   = 40'h00_0001_ffff;

    typedef logic [DATA_W-1:0] word_t;
    typedef struct {
        logic [7:0] id;
        word_t      data;
        logic [1:0] resp;
        logic       last;
    } beat_t;

    logic              cpu_clk = 1'b0;
    logic              cpu_rst_b;
    logic [39:0]       pad_araddr;
    logic [1:0]        pad_arburst;
    logic [7:0]        pad_arid;
    logic [7:0]        pad_arlen;
    logic [2:0]        pad_arsize;
    logic              pad_arvalid;
    logic              pad_arready;
    logic [7:0]        pad_rid;
    word_t             pad_rdata;
    logic [1:0]        pad_rresp;
    logic              pad_rlast;
    logic              pad_rvalid;
    logic              pad_rready;
    logic              mem_cen;
    logic [MEM_AW-1:0] mem_addr;
    word_t             mem_rdata;

    always #5 cpu_clk = ~cpu_clk;

    axi_rd_slave #(
        .DATA_W    (DATA_W),
        .MEM_AW    (MEM_AW),
        .SRAM_START(SRAM_START),
        .SRAM_END  (SRAM_END)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst_b  (cpu_rst_b),
        .pad_araddr (pad_araddr),
        .pad_arburst(pad_arburst),
        .pad_arid   (pad_arid),
        .pad_arlen  (pad_arlen),
        .pad_arsize (pad_arsize),
        .pad_arvalid(pad_arvalid),
        .pad_arready(pad_arready),
        .pad_rid    (pad_rid),
        .pad_rdata  (pad_rdata),
        .pad_rresp  (pad_rresp),
        .pad_rlast  (pad_rlast),
        .pad_rvalid (pad_rvalid),
        .pad_rready (pad_rready),
        .mem_cen    (mem_cen),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    // SRAM model; garbage on idle cycles exposes error beats that fail to zero rdata.
    word_t mem [1 << MEM_AW];
    always @(posedge cpu_clk) begin
        if (mem_cen) mem_rdata <= mem[mem_addr];
        else         mem_rdata <= {$urandom, $urandom, $urandom, $urandom};
    end

    beat_t             exp_q[$];
    logic [MEM_AW-1:0] maddr_q[$];
    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    int rmode = 0;  // 0 ready, 1 stalled, 2 toggle, 3 random

    task automatic chk(input string name, input word_t act, input word_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string why);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Reference model: every beat of the burst computed directly from its index.
    task automatic model_ar(input logic [39:0] addr, input logic [1:0] burst,
                            input logic [7:0] id, input logic [7:0] len, input logic [2:0] size);
        logic [1:0]  resp;
        logic [39:0] bytes, bound, base, a;
        beat_t       e;
        bytes = 40'd1 << size;
        if ((addr - SRAM_START) > (SRAM_END - SRAM_START)) resp = 2'b11;
        else if (size > 3'd4 || burst == 2'b11 ||
                 (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)))
            resp = 2'b10;
        else resp = 2'b00;
        bound = ({32'd0, len} + 40'd1) * bytes;
        base  = (addr / bound) * bound;
        for (int n = 0; n <= int'(len); n++) begin
            case (burst)
                2'b00:   a = addr;
                2'b10:   a = base + ((addr - base + 40'(n) * bytes) % bound);
                default: a = (n == 0) ? addr : (addr / bytes) * bytes + 40'(n) * bytes;
            endcase
            e.id   = id;
            e.resp = resp;
            e.last = (n == int'(len));
            e.data = (resp == 2'b00) ? mem[a[MEM_AW+3:4]] : '0;
            exp_q.push_back(e);
            if (resp == 2'b00) maddr_q.push_back(a[MEM_AW+3:4]);
        end
    endtask

    // Call just after a rising edge; returns just after the handshake edge.
    task automatic ar_send(input logic [39:0] addr, input logic [1:0] burst,
                           input logic [7:0] id, input logic [7:0] len, input logic [2:0] size);
        bit done = 1'b0;
        pad_araddr  = addr;
        pad_arburst = burst;
        pad_arid    = id;
        pad_arlen   = len;
        pad_arsize  = size;
        pad_arvalid = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge cpu_clk);
            if (pad_arready) begin
                @(posedge cpu_clk);
                #1;
                done = 1'b1;
            end
        end
        pad_arvalid = 1'b0;
        if (done) model_ar(addr, burst, id, len, size);
        else fail("ar_handshake", "arready never asserted");
    endtask

    task automatic drain(input string name);
        int i = 0;
        while ((exp_q.size() != 0 || maddr_q.size() != 0) && i < 3000) begin
            @(posedge cpu_clk);
            #1;
            i++;
        end
        if (exp_q.size() != 0 || maddr_q.size() != 0)
            fail(name, $sformatf("%0d beats and %0d SRAM reads still outstanding",
                                 exp_q.size(), maddr_q.size()));
    endtask

    initial begin
        pad_rready = 1'b0;
        forever begin
            @(posedge cpu_clk);
            #1;
            case (rmode)
                0:       pad_rready = 1'b1;
                1:       pad_rready = 1'b0;
                2:       pad_rready = ~pad_rready;
                default: pad_rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pops on R handshakes and SRAM reads, plus stall stability.
    initial begin
        beat_t      e;
        logic       stall;
        logic [7:0] p_id;
        word_t      p_data;
        logic [1:0] p_resp;
        logic       p_last;
        stall = 1'b0;
        forever begin
            @(negedge cpu_clk);
            if (!cpu_rst_b) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_ctl", word_t'({pad_rvalid, pad_rid, pad_rresp, pad_rlast}),
                        word_t'({1'b1, p_id, p_resp, p_last}));
                    chk("stall_data", pad_rdata, p_data);
                end
                if (pad_rvalid && pad_rready) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        fail("r_unexpected", $sformatf("beat id %0h with nothing expected",
                                                       pad_rid));
                    end else begin
                        e = exp_q.pop_front();
                        chk("r_id_resp_last", word_t'({pad_rid, pad_rresp, pad_rlast}),
                            word_t'({e.id, e.resp, e.last}));
                        chk("r_data", pad_rdata, e.data);
                    end
                end
                if (mem_cen) begin
                    if (maddr_q.size() == 0)
                        fail("mem_unexpected", $sformatf("read of %0h", mem_addr));
                    else
                        chk("mem_addr", word_t'(mem_addr), word_t'(maddr_q.pop_front()));
                end
                stall  = pad_rvalid && !pad_rready;
                p_id   = pad_rid;
                p_data = pad_rdata;
                p_resp = pad_rresp;
                p_last = pad_rlast;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] a;
        logic [1:0]  b;
        logic [7:0]  l;
        logic [2:0]  s;
        int          base_beats;
        int          r;
        cpu_rst_b   = 1'b0;
        pad_arvalid = 1'b0;
        pad_araddr  = '0;
        pad_arburst = '0;
        pad_arid    = '0;
        pad_arlen   = '0;
        pad_arsize  = '0;
        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) @(posedge cpu_clk);
        #1;
        chk("rst_arready", word_t'(pad_arready), '0);
        chk("rst_r_ctl", word_t'({pad_rvalid, pad_rlast, pad_rid, pad_rresp}), '0);
        chk("rst_rdata", pad_rdata, '0);
        chk("rst_mem", word_t'({mem_cen, mem_addr}), '0);
        cpu_rst_b = 1'b1;
        #1;
        chk("arready_after_rst", word_t'(pad_arready), word_t'(1));
        @(posedge cpu_clk);
        #1;

        // INCR latency: mem_cen in cycle 1, rvalid from cycle 3 for 4 consecutive beats.
        ar_send(40'h100, 2'b01, 8'h11, 8'd3, 3'd4);
        @(negedge cpu_clk);
        chk("lat_cen_c1", word_t'(mem_cen), word_t'(1));
        @(negedge cpu_clk);
        chk("lat_rvalid_c2", word_t'(pad_rvalid), '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge cpu_clk);
            chk("lat_rvalid_run", word_t'({pad_rvalid, pad_rlast}), word_t'({1'b1, k == 3}));
        end
        @(posedge cpu_clk);
        #1;
        drain("drain_incr");

        ar_send(40'h130, 2'b10, 8'h22, 8'd3, 3'd4);
        drain("drain_wrap");

        ar_send(40'h20000, 2'b01, 8'h33, 8'd1, 3'd4);
        drain("drain_decerr");

        // Queue fill under full backpressure.
        rmode = 1;
        @(posedge cpu_clk);
        #1;
        ar_send(40'h200, 2'b01, 8'h01, 8'd1, 3'd4);
        ar_send(40'h300, 2'b01, 8'h02, 8'd1, 3'd4);
        ar_send(40'h400, 2'b01, 8'h03, 8'd1, 3'd4);
        repeat (4) @(posedge cpu_clk);
        #1;
        chk("arready_full", word_t'({pad_arready, pad_rvalid}), word_t'(2'b01));
        rmode = 0;
        drain("drain_backpressure");

        rmode = 2;
        ar_send(40'h1000, 2'b01, 8'h55, 8'd7, 3'd4);
        drain("drain_toggle");
        rmode = 0;

        // Reset while beat 2 of a len 7 burst is presented.
        @(posedge cpu_clk);
        #1;
        base_beats = beats_seen;
        ar_send(40'h2000, 2'b01, 8'h66, 8'd7, 3'd4);
        for (int i = 0; i < 50 && beats_seen < base_beats + 2; i++) begin
            @(posedge cpu_clk);
            #1;
        end
        chk("reset_beats_before", word_t'(beats_seen - base_beats), word_t'(2));
        cpu_rst_b = 1'b0;
        #1;
        chk("reset_rvalid", word_t'({pad_rvalid, mem_cen}), '0);
        exp_q.delete();
        maddr_q.delete();
        @(posedge cpu_clk);
        #1;
        chk("reset_arready", word_t'(pad_arready), '0);
        cpu_rst_b = 1'b1;
        #1;
        chk("reset_release_arready", word_t'(pad_arready), word_t'(1));
        @(posedge cpu_clk);
        #1;
        ar_send(40'h40, 2'b01, 8'h77, 8'd0, 3'd4);
        drain("drain_after_reset");

        // Randomized bursts with random backpressure.
        rmode = 3;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            b = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            if (b == 2'b10 && $urandom_range(0, 4) != 0) l = 8'((1 << $urandom_range(1, 4)) - 1);
            else l = 8'($urandom_range(0, 15));
            r = $urandom_range(0, 7);
            if (r == 0)      a = 40'h20000 + 40'($urandom_range(0, 4095));
            else if (r == 1) a = 40'h80_0000_0000 | 40'($urandom);
            else             a = 40'($urandom_range(0, 32'h1ffff));
            ar_send(a, b, 8'($urandom), l, s);
            repeat ($urandom_range(0, 3)) @(posedge cpu_clk);
            #1;
        end
        rmode = 0;
        drain("drain_random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
